// File: rtl/i2c_target.sv
// I2C target for one 7-bit address with a byte-stream interface to local logic.
// Open-drain pads: *_o is tied low and *_oen_o=1 pulls the line low.
module i2c_target #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] own_addr_i,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_oen_o,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_first_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       stop_o
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_LOAD,
    S_RD_DATA,
    S_RD_ACK,
    S_IGNORE
  } state_t;

  logic [1:0]       scl_sync;
  logic [1:0]       sda_sync;
  logic [CNT_W-1:0] scl_cnt;
  logic [CNT_W-1:0] sda_cnt;
  logic             scl_f;
  logic             sda_f;
  logic             scl_d;
  logic             sda_d;

  logic             scl_rise;
  logic             scl_fall;
  logic             sda_rise;
  logic             sda_fall;
  logic             start_det;
  logic             stop_det;

  state_t           state;
  logic [7:0]       sr;
  logic [3:0]       bit_cnt;
  logic             rw;
  logic             first;
  logic [6:0]       addr_lat;

  assign scl_o = 1'b0;
  assign sda_o = 1'b0;

  // Two-flop synchronizers; preset to the idle-high bus level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

  // Glitch filters: a level change needs FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
      scl_d   <= 1'b1;
      sda_d   <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FILT_MAX) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + CNT_W'(1);
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FILT_MAX) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + CNT_W'(1);
      end
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign sda_rise = sda_f & ~sda_d;
  assign sda_fall = ~sda_f & sda_d;
  // SCL must be high before and after the SDA edge, so a simultaneous
  // SCL release and SDA change (read bit 7) is never taken as START/STOP.
  assign start_det = sda_fall & scl_f & scl_d;
  assign stop_det  = sda_rise & scl_f & scl_d;

  // Protocol state machine with registered pad enables and stream outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      rw         <= 1'b0;
      first      <= 1'b0;
      addr_lat   <= '0;
      scl_oen_o  <= 1'b0;
      sda_oen_o  <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      rx_first_o <= 1'b0;
      tx_ready_o <= 1'b0;
      busy_o     <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      stop_o     <= 1'b0;
      if (stop_det) begin
        state      <= S_IDLE;
        stop_o     <= busy_o;
        busy_o     <= 1'b0;
        scl_oen_o  <= 1'b0;
        sda_oen_o  <= 1'b0;
        tx_ready_o <= 1'b0;
      end else if (start_det) begin
        state      <= S_ADDR;
        addr_lat   <= own_addr_i;
        bit_cnt    <= '0;
        busy_o     <= 1'b0;
        scl_oen_o  <= 1'b0;
        sda_oen_o  <= 1'b0;
        tx_ready_o <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              sr      <= {sr[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (sr[7:1] == addr_lat) begin
                state     <= S_ADDR_ACK;
                rw        <= sr[0];
                sda_oen_o <= 1'b1;
                busy_o    <= 1'b1;
                first     <= 1'b1;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              sda_oen_o <= 1'b0;
              bit_cnt   <= '0;
              if (rw) begin
                state      <= S_RD_LOAD;
                tx_ready_o <= 1'b1;
                scl_oen_o  <= 1'b1;
              end else begin
                state <= S_WR_DATA;
              end
            end
          end
          S_WR_DATA: begin
            if (scl_rise) begin
              sr      <= {sr[6:0], sda_f};
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                rx_data_o  <= {sr[6:0], sda_f};
                rx_valid_o <= 1'b1;
                rx_first_o <= first;
                first      <= 1'b0;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state     <= S_WR_ACK;
              sda_oen_o <= 1'b1;
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              state     <= S_WR_DATA;
              sda_oen_o <= 1'b0;
              bit_cnt   <= '0;
            end
          end
          S_RD_LOAD: begin
            if (tx_valid_i && tx_ready_o) begin
              state      <= S_RD_DATA;
              sr         <= tx_data_i;
              tx_ready_o <= 1'b0;
              scl_oen_o  <= 1'b0;
              sda_oen_o  <= ~tx_data_i[7];
              bit_cnt    <= '0;
            end
          end
          S_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                state     <= S_RD_ACK;
                sda_oen_o <= 1'b0;
                bit_cnt   <= '0;
              end else begin
                sr        <= {sr[6:0], 1'b0};
                sda_oen_o <= ~sr[6];
                bit_cnt   <= bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise && sda_f) begin
              state <= S_IGNORE;
            end else if (scl_fall) begin
              state      <= S_RD_LOAD;
              tx_ready_o <= 1'b1;
              scl_oen_o  <= 1'b1;
            end
          end
          S_IGNORE: begin
            scl_oen_o <= 1'b0;
            sda_oen_o <= 1'b0;
          end
          default: begin
            state     <= S_IDLE;
            scl_oen_o <= 1'b0;
            sda_oen_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged controller on a wired-AND bus.
module tb_i2c_target;

  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] own_addr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       scl_o, scl_oen, sda_o, sda_oen;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first, tx_ready, busy, stop;

  logic ctrl_scl_pull, ctrl_sda_pull;
  logic scl_line, sda_line;
  logic gl_scl, gl_sda;

  int total = 0;
  int bad   = 0;

  logic [8:0] rxq[$];
  int         stop_cnt;
  logic       oen_seen, rdy_seen;

  assign scl_line = ~(ctrl_scl_pull | scl_oen);
  assign sda_line = ~(ctrl_sda_pull | sda_oen);

  i2c_target #(.FILTER_LEN(3)) dut (
    .clk_i(clk), .rst_i(rst), .own_addr_i(own_addr),
    .scl_i(scl_line), .scl_o(scl_o), .scl_oen_o(scl_oen),
    .sda_i(sda_line), .sda_o(sda_o), .sda_oen_o(sda_oen),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_first_o(rx_first),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .busy_o(busy), .stop_o(stop)
  );

  always #5 clk = ~clk;

  // Event log sampled on the inactive edge.
  always @(negedge clk) begin
    if (rx_valid) rxq.push_back({rx_first, rx_data});
    if (stop) stop_cnt++;
    if (sda_oen) oen_seen = 1'b1;
    if (tx_ready) rdy_seen = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    rxq.delete();
    stop_cnt = 0;
    oen_seen = 1'b0;
    rdy_seen = 1'b0;
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (scl_line !== 1'b1 && t < 4000) begin
      tick(1);
      t++;
    end
    if (t >= 4000) begin
      total++;
      bad++;
      $display("FAIL scl_release: got stretched expected released within 4000 clks");
    end
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 4000) begin
      tick(1);
      t++;
    end
    if (t >= 4000) begin
      total++;
      bad++;
      $display("FAIL %s: got no tx_ready expected tx_ready within 4000 clks", name);
    end
  endtask

  task automatic bus_bit(input logic b, output logic s);
    ctrl_sda_pull = ~b;
    if (gl_scl) begin
      tick(H/2);
      ctrl_scl_pull = 1'b0;
      tick(1);
      ctrl_scl_pull = 1'b1;
      tick(H/2);
    end else begin
      tick(H);
    end
    ctrl_scl_pull = 1'b0;
    wait_scl_high();
    if (gl_sda) begin
      tick(H/2);
      ctrl_sda_pull = ~ctrl_sda_pull;
      tick(2);
      ctrl_sda_pull = ~ctrl_sda_pull;
      tick(H/2);
    end else begin
      tick(H);
    end
    s = sda_line;
    ctrl_scl_pull = 1'b1;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    gl_scl = 1'b0;
    gl_sda = 1'b0;
    bus_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic s;
    logic [7:0] tmp;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      tmp[i] = s;
    end
    bus_bit(~ack, s);
    d = tmp;
  endtask

  task automatic bus_start();
    ctrl_sda_pull = 1'b0;
    tick(H);
    ctrl_scl_pull = 1'b0;
    wait_scl_high();
    tick(H);
    ctrl_sda_pull = 1'b1;
    tick(H);
    ctrl_scl_pull = 1'b1;
    tick(4);
  endtask

  task automatic bus_stop();
    ctrl_sda_pull = 1'b1;
    tick(H);
    ctrl_scl_pull = 1'b0;
    wait_scl_high();
    tick(H);
    ctrl_sda_pull = 1'b0;
    tick(H);
  endtask

  typedef struct {
    logic [6:0] own;
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic a0, a1, a2, busy_mid, s0, s1, s2;
    logic [7:0] d1, d2;
    int hi;

    vecs[0] = '{7'h2A, 8'h54, 8'hA5, 8'h3C, 1'b1};
    vecs[1] = '{7'h2A, 8'h56, 8'h12, 8'h34, 1'b0};
    vecs[2] = '{7'h2A, 8'h00, 8'h77, 8'h88, 1'b0};
    vecs[3] = '{7'h00, 8'h00, 8'h0F, 8'hF0, 1'b1};
    vecs[4] = '{7'h7F, 8'hFE, 8'hFF, 8'h00, 1'b1};

    rst = 1'b1;
    own_addr = 7'h2A;
    tx_data = 8'h00;
    tx_valid = 1'b0;
    ctrl_scl_pull = 1'b0;
    ctrl_sda_pull = 1'b0;
    gl_scl = 1'b0;
    gl_sda = 1'b0;
    clear_log();
    tick(5);
    check("reset_outputs",
          {scl_o, scl_oen, sda_o, sda_oen, rx_valid, rx_first, tx_ready, busy, stop, rx_data},
          32'h0);
    rst = 1'b0;
    tick(10);

    // Write transactions from the vector table.
    for (int v = 0; v < 5; v++) begin
      own_addr = vecs[v].own;
      clear_log();
      bus_start();
      send_byte(vecs[v].addr, a0);
      busy_mid = busy;
      send_byte(vecs[v].d0, a1);
      send_byte(vecs[v].d1, a2);
      bus_stop();
      tick(10);
      check($sformatf("v%0d_addr_ack", v), a0, vecs[v].ack);
      check($sformatf("v%0d_data_ack", v), {a1, a2}, {vecs[v].ack, vecs[v].ack});
      check($sformatf("v%0d_busy", v), busy_mid, vecs[v].ack);
      check($sformatf("v%0d_rx_count", v), rxq.size(), vecs[v].ack ? 2 : 0);
      if (rxq.size() == 2 && vecs[v].ack) begin
        check($sformatf("v%0d_rx0", v), rxq[0], {1'b1, vecs[v].d0});
        check($sformatf("v%0d_rx1", v), rxq[1], {1'b0, vecs[v].d1});
      end
      check($sformatf("v%0d_stop_cnt", v), stop_cnt, vecs[v].ack ? 1 : 0);
      check($sformatf("v%0d_oen_seen", v), oen_seen, vecs[v].ack);
      check($sformatf("v%0d_no_ready", v), rdy_seen, 1'b0);
      check($sformatf("v%0d_busy_after", v), busy, 1'b0);
    end

    // Read with a 20-clk stretch, then a back-to-back byte, then NACK.
    own_addr = 7'h2A;
    clear_log();
    bus_start();
    send_byte(8'h55, a0);
    check("rd_addr_ack", a0, 1'b1);
    fork
      begin
        read_byte(d1, 1'b1);
        read_byte(d2, 1'b0);
      end
      begin
        wait_ready("rd_ready1");
        hi = 0;
        for (int i = 0; i < 20; i++) begin
          if (scl_oen) hi++;
          tick(1);
        end
        check("rd_stretch_cycles", hi, 20);
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        tick(1);
        check("rd_handshake1", {tx_ready, scl_oen, sda_oen}, 3'b000);
        tx_data = 8'h81;
        wait_ready("rd_ready2");
        tick(1);
        check("rd_handshake2", {tx_ready, scl_oen}, 2'b00);
      end
    join
    tx_valid = 1'b0;
    tick(10);
    check("rd_byte1", d1, 8'hC3);
    check("rd_byte2", d2, 8'h81);
    check("rd_after_nack", {tx_ready, busy, sda_oen}, 3'b010);
    bus_stop();
    tick(10);
    check("rd_stop_cnt", stop_cnt, 1);
    check("rd_no_rx", rxq.size(), 0);

    // Write then repeated START into a read.
    clear_log();
    tx_data = 8'h99;
    tx_valid = 1'b1;
    bus_start();
    send_byte(8'h54, a0);
    send_byte(8'h11, a1);
    bus_start();
    check("rs_no_stop", {stop_cnt[3:0], busy}, 5'b0);
    send_byte(8'h55, a2);
    read_byte(d1, 1'b0);
    bus_stop();
    tx_valid = 1'b0;
    tick(10);
    check("rs_acks", {a0, a1, a2}, 3'b111);
    check("rs_rx_count", rxq.size(), 1);
    if (rxq.size() == 1) check("rs_rx0", rxq[0], {1'b1, 8'h11});
    check("rs_rd_byte", d1, 8'h99);
    check("rs_stop_cnt", stop_cnt, 1);

    // Glitches: 1-clk SCL pulse in each low phase, 2-clk SDA flip in each high phase.
    clear_log();
    bus_start();
    send_byte(8'h54, a0);
    gl_scl = 1'b1;
    gl_sda = 1'b1;
    send_byte(8'h5A, a1);
    check("gl_busy_kept", {busy, stop_cnt[3:0]}, 5'b10000);
    bus_stop();
    tick(10);
    check("gl_acks", {a0, a1}, 2'b11);
    check("gl_rx_count", rxq.size(), 1);
    if (rxq.size() == 1) check("gl_rx0", rxq[0], {1'b1, 8'h5A});
    check("gl_stop_cnt", stop_cnt, 1);

    // Asynchronous reset while bit 4 (a 0) of a read is driven.
    clear_log();
    tx_data = 8'hE0;
    tx_valid = 1'b1;
    bus_start();
    send_byte(8'h55, a0);
    bus_bit(1'b1, s0);
    bus_bit(1'b1, s1);
    bus_bit(1'b1, s2);
    tick(6);
    check("rst_pre_bits", {a0, s0, s1, s2}, 4'b1111);
    check("rst_pre_sda_low", sda_oen, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_release", {sda_oen, scl_oen, busy, tx_ready}, 4'b0000);
    ctrl_scl_pull = 1'b0;
    ctrl_sda_pull = 1'b0;
    tx_valid = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(10);
    clear_log();
    bus_start();
    send_byte(8'h54, a0);
    send_byte(8'h77, a1);
    bus_stop();
    tick(10);
    check("post_rst_acks", {a0, a1}, 2'b11);
    check("post_rst_rx_count", rxq.size(), 1);
    if (rxq.size() == 1) check("post_rst_rx0", rxq[0], {1'b1, 8'h77});
    check("post_rst_stop_cnt", stop_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
